// File: rtl/pipe_reg_neg.sv
// Falling-edge pipeline register: DEPTH stages of WIDTH-bit data, each with a valid bit.
// Stages can stall (ena) and flush (clr); a registered occupancy count drives full/empty.
module pipe_reg_neg #(
    parameter int  WIDTH    = 32,
    parameter int  DEPTH    = 4,
    parameter bit  CLR_DATA = 1'b1,
    localparam int CW       = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             ena,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    output logic [CW-1:0]    occupancy,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] data_reg  [DEPTH];
    logic [WIDTH-1:0] data_next [DEPTH];
    logic [DEPTH-1:0] valid_reg;
    logic [DEPTH-1:0] valid_next;
    logic [CW-1:0]    occupancy_reg;
    logic [CW-1:0]    occupancy_next;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic [WIDTH-1:0] shift_data;
            logic             shift_valid;

            if (gi == 0) begin : g_head
                assign shift_data  = d;
                assign shift_valid = d_valid;
            end else begin : g_body
                assign shift_data  = data_reg[gi-1];
                assign shift_valid = valid_reg[gi-1];
            end

            // Flush beats advance, advance beats hold.
            assign valid_next[gi] = clr ? 1'b0
                                  : (ena ? shift_valid : valid_reg[gi]);
            assign data_next[gi]  = clr ? (CLR_DATA ? '0 : data_reg[gi])
                                  : (ena ? shift_data : data_reg[gi]);
        end
    endgenerate

    // Occupancy is recounted from the next-state valid bits every edge.
    always_comb begin
        occupancy_next = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupancy_next = occupancy_next + CW'(valid_next[i]);
        end
    end

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_reg[i] <= '0;
            end
            valid_reg     <= '0;
            occupancy_reg <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                data_reg[i] <= data_next[i];
            end
            valid_reg     <= valid_next;
            occupancy_reg <= occupancy_next;
        end
    end

    assign q         = data_reg[DEPTH-1];
    assign q_valid   = valid_reg[DEPTH-1];
    assign occupancy = occupancy_reg;
    assign empty     = (occupancy_reg == '0);
    assign full      = (occupancy_reg == CW'(DEPTH));

endmodule

// File: tb/tb_pipe_reg_neg.sv
// Bench for pipe_reg_neg: three instances (DEPTH=4 with and without data clear, DEPTH=1)
// share one stimulus stream and are checked against queue-based pipeline models.
module tb_pipe_reg_neg;

    typedef struct {
        logic [31:0] data;
        logic        valid;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clr = 1'b0;
    logic        ena = 1'b0;
    logic [31:0] d = '0;
    logic        d_valid = 1'b0;

    logic [31:0] q_a, q_b, q_c;
    logic        qv_a, qv_b, qv_c;
    logic [2:0]  occ_a, occ_b;
    logic [0:0]  occ_c;
    logic        empty_a, empty_b, empty_c;
    logic        full_a, full_b, full_c;

    int total = 0;
    int bad   = 0;

    ent_t pa[$];
    ent_t pb[$];
    ent_t pc[$];

    always #5 clk = ~clk;

    pipe_reg_neg #(.WIDTH(32), .DEPTH(4), .CLR_DATA(1'b1)) dut_a (
        .clk(clk), .reset(reset), .clr(clr), .ena(ena), .d(d), .d_valid(d_valid),
        .q(q_a), .q_valid(qv_a), .occupancy(occ_a), .empty(empty_a), .full(full_a)
    );

    pipe_reg_neg #(.WIDTH(32), .DEPTH(4), .CLR_DATA(1'b0)) dut_b (
        .clk(clk), .reset(reset), .clr(clr), .ena(ena), .d(d), .d_valid(d_valid),
        .q(q_b), .q_valid(qv_b), .occupancy(occ_b), .empty(empty_b), .full(full_b)
    );

    pipe_reg_neg #(.WIDTH(32), .DEPTH(1), .CLR_DATA(1'b1)) dut_c (
        .clk(clk), .reset(reset), .clr(clr), .ena(ena), .d(d), .d_valid(d_valid),
        .q(q_c), .q_valid(qv_c), .occupancy(occ_c), .empty(empty_c), .full(full_c)
    );

    task automatic model_reset();
        pa.delete(); pb.delete(); pc.delete();
        repeat (4) pa.push_back('{data: 32'd0, valid: 1'b0});
        repeat (4) pb.push_back('{data: 32'd0, valid: 1'b0});
        pc.push_back('{data: 32'd0, valid: 1'b0});
    endtask

    // Pipeline as a queue: new word enters at the front, oldest falls off the back.
    task automatic model_edge();
        if (reset) return;
        if (clr) begin
            foreach (pa[i]) pa[i] = '{data: 32'd0, valid: 1'b0};
            foreach (pb[i]) pb[i].valid = 1'b0;
            foreach (pc[i]) pc[i] = '{data: 32'd0, valid: 1'b0};
        end else if (ena) begin
            pa.push_front('{data: d, valid: d_valid}); void'(pa.pop_back());
            pb.push_front('{data: d, valid: d_valid}); void'(pb.pop_back());
            pc.push_front('{data: d, valid: d_valid}); void'(pc.pop_back());
        end
    endtask

    function automatic int count_valid(input ent_t p[$]);
        int n = 0;
        foreach (p[i]) n += int'(p[i].valid);
        return n;
    endfunction

    task automatic check_one(input string tag, input string inst, input logic [31:0] q_o,
                             input logic qv_o, input int occ_o, input logic e_o,
                             input logic f_o, input ent_t p[$]);
        int n;
        int depth;
        n = count_valid(p);
        depth = p.size();
        total += 5;
        assert (q_o === p[depth-1].data) else begin
            bad++; $error("FAIL %s.%s q got=%h exp=%h", tag, inst, q_o, p[depth-1].data);
        end
        assert (qv_o === p[depth-1].valid) else begin
            bad++; $error("FAIL %s.%s q_valid got=%b exp=%b", tag, inst, qv_o, p[depth-1].valid);
        end
        assert (occ_o == n) else begin
            bad++; $error("FAIL %s.%s occupancy got=%0d exp=%0d", tag, inst, occ_o, n);
        end
        assert (e_o === (n == 0)) else begin
            bad++; $error("FAIL %s.%s empty got=%b exp=%b", tag, inst, e_o, (n == 0));
        end
        assert (f_o === (n == depth)) else begin
            bad++; $error("FAIL %s.%s full got=%b exp=%b", tag, inst, f_o, (n == depth));
        end
    endtask

    task automatic check_all(input string tag);
        check_one(tag, "a", q_a, qv_a, int'(occ_a), empty_a, full_a, pa);
        check_one(tag, "b", q_b, qv_b, int'(occ_b), empty_b, full_b, pb);
        check_one(tag, "c", q_c, qv_c, int'(occ_c), empty_c, full_c, pc);
        $display("%-8s t=%0t q_a=%h v=%b occ=%0d | q_b=%h | q_c=%h v=%b",
                 tag, $time, q_a, qv_a, occ_a, q_b, q_c, qv_c);
    endtask

    task automatic step(input string tag, input logic c, input logic e,
                        input logic [31:0] dd, input logic dv);
        clr = c; ena = e; d = dd; d_valid = dv;
        @(negedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        #1;
        check_all("reset");
        #1 reset = 1'b0;

        // Latency: four valid words, the first reaches q after the 4th edge.
        for (int i = 1; i <= 4; i++) step("latency", 1'b0, 1'b1, 32'hA5A5_0000 + i, 1'b1);
        total++;
        assert (q_a === 32'hA5A5_0001 && full_a === 1'b1) else begin
            bad++; $error("FAIL latency_final q=%h full=%b exp=a5a50001/1", q_a, full_a);
        end

        // Async reset mid-stream with three valid stages, no edge in between.
        step("prefill", 1'b1, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) step("fill3", 1'b0, 1'b1, 32'h1000_0000 + i, 1'b1);
        #2 reset = 1'b1;
        model_reset();
        #1 check_all("areset");
        step("rst_hold", 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1);
        reset = 1'b0;

        // Stall: two words in, three stalled edges with changing d, then resume.
        for (int i = 0; i < 2; i++) step("stl_fill", 1'b0, 1'b1, 32'h2000_0000 + i, 1'b1);
        for (int i = 0; i < 3; i++) step("stall", 1'b0, 1'b0, $urandom, 1'b1);
        for (int i = 0; i < 4; i++) step("resume", 1'b0, 1'b1, 32'h0, 1'b0);

        // Flush with three occupied stages while ena/d would load a valid word.
        for (int i = 0; i < 4; i++) step("fl_fill", 1'b0, 1'b1, 32'h3000_0000 + i, (i != 0));
        step("flush", 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1);

        // Bubbles: alternating valid pattern never holds more than two stages.
        for (int i = 0; i < 8; i++) begin
            step("bubble", 1'b0, 1'b1, $urandom, ((i % 2) == 0));
            total++;
            assert (occ_a <= 3'd2) else begin
                bad++; $error("FAIL bubble_occ got=%0d exp<=2", occ_a);
            end
        end

        // Edge sense: wiggle inputs around posedge only, nothing may move.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            d = $urandom; d_valid = 1'b1; ena = 1'b1; clr = (i == 1);
            #2 check_all("posedge");
            ena = 1'b0; clr = 1'b0;
        end
        step("dep1", 1'b0, 1'b1, 32'h0000_0005, 1'b1);

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            step("rand", ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
                 $urandom, 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
